// File: rtl/ex_pkg.sv
// Shared types and encodings for the EX-stage multiply/divide controller.
package ex_pkg;

   localparam int MULDIV_ITER = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      MULTU = OP_MULTU,
      MULT  = OP_MULT,
      DIVU  = OP_DIVU,
      DIV   = OP_DIV
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } muldiv_state_e;

   function automatic logic op_is_div(input muldiv_op_e o);
      return (o == DIVU) || (o == DIV);
   endfunction

   function automatic logic op_is_signed(input muldiv_op_e o);
      return (o == MULT) || (o == DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// over the {part, low} double-width accumulator.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] part,
   input  logic [WIDTH-1:0] low,
   input  logic [WIDTH-1:0] operand,
   input  logic             is_div,
   output logic [WIDTH-1:0] next_part,
   output logic [WIDTH-1:0] next_low,
   output logic             q_bit
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sum       = {1'b0, part} + (low[0] ? {1'b0, operand} : '0);
      shifted   = {part, low[WIDTH-1]};
      diff      = shifted - {1'b0, operand};
      q_bit     = 1'b0;
      next_part = part;
      next_low  = low;
      if (is_div) begin
         q_bit     = (shifted >= {1'b0, operand});
         next_part = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         next_low  = {low[WIDTH-2:0], q_bit};
      end else begin
         // multiplier bits retire from the bottom while product bits enter at the top
         next_part = sum[WIDTH:1];
         next_low  = {sum[0], low[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_controller.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU sequencer with pipeline stall and
// architectural HI/LO registers.
module ex_muldiv_controller
   import ex_pkg::*;
#(
   parameter int WIDTH = MULDIV_ITER,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(ITER);

   muldiv_state_e    state, state_next;
   logic [CW-1:0]    cnt;
   muldiv_op_e       op_q;
   logic [WIDTH-1:0] acc_hi, acc_lo, operand;
   logic             sign_a, sign_b, dbz;
   logic             load, cnt_last;

   logic [WIDTH-1:0] next_part, next_low;
   logic             q_bit_unused;
   logic [WIDTH-1:0] fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;

   muldiv_op_e       op_in;
   logic             signed_in;

   assign op_in     = muldiv_op_e'(op);
   assign signed_in = op_is_signed(op_in);
   assign load      = start && !flush && (state == IDLE || state == DONE);
   assign cnt_last  = (cnt == CW'(ITER - 1));

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start && !flush) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (flush)         state_next = IDLE;
            else if (cnt_last) state_next = FIX;
         end
         FIX: begin
            busy       = 1'b1;
            state_next = flush ? IDLE : DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = (start && !flush) ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
      stall       = (start && (state == IDLE || state == DONE)) || busy;
      div_by_zero = done && dbz;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .part      (acc_hi),
      .low       (acc_lo),
      .operand   (operand),
      .is_div    (op_is_div(op_q)),
      .next_part (next_part),
      .next_low  (next_low),
      .q_bit     (q_bit_unused)
   );

   // NOTE: the iteration datapath is fully loaded on start, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         op_q    <= op_in;
         acc_hi  <= '0;
         acc_lo  <= (signed_in && rs_data[WIDTH-1]) ? -rs_data : rs_data;
         operand <= (signed_in && rt_data[WIDTH-1]) ? -rt_data : rt_data;
         sign_a  <= signed_in && rs_data[WIDTH-1];
         sign_b  <= signed_in && rt_data[WIDTH-1];
         dbz     <= op_is_div(op_in) && (rt_data == '0);
      end else if (state == RUN) begin
         acc_hi <= next_part;
         acc_lo <= next_low;
      end
   end

   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = (sign_a ^ sign_b) ? -prod : prod;
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (op_is_div(op_q)) begin
         // with a zero divisor the remainder ends up as |dividend|, so the
         // dividend-sign rule restores the original signed dividend
         fix_hi = sign_a ? -acc_hi : acc_hi;
         fix_lo = dbz ? '1 : ((sign_a ^ sign_b) ? -acc_lo : acc_lo);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         cnt <= '0;
         hi  <= '0;
         lo  <= '0;
      end else begin
         if (load)               cnt <= '0;
         else if (state == RUN)  cnt <= cnt + 1'b1;
         if (state == FIX && !flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_controller.sv
// Self-checking bench for ex_muldiv_controller: directed corner cases plus
// randomized ops against a plain-arithmetic HI/LO reference.
module tb_ex_muldiv_controller;

   logic        clk;
   logic        rst_b;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data, rt_data;
   logic        flush;
   logic        stall, busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   ex_muldiv_controller dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .start       (start),
      .op          (op),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .flush       (flush),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output logic ed);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ed = 1'b0;
      eh = '0;
      el = '0;
      case (o)
         2'b00: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
         2'b01: begin p = sa * sb;                 eh = p[63:32]; el = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               el = 32'hFFFF_FFFF; eh = a; ed = 1'b1;
            end else if (o == 2'b10) begin
               el = a / b; eh = a % b;
            end else begin
               q = sa / sb; r = sa % sb;
               el = q[31:0]; eh = r[31:0];
            end
         end
      endcase
   endfunction

   task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      #1 check({tag, "_stall_issue"}, 64'(stall), 64'(1));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el, input logic ed);
      int cyc = 1;
      while (done !== 1'b1 && cyc < 60) begin
         check({tag, "_stall_run"}, 64'(stall), 64'(1));
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(34));
      check({tag, "_done"}, 64'(done), 64'(1));
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed, input bit idle_after);
      issue(tag, o, a, b);
      wait_done(tag, eh, el, ed);
      if (idle_after) begin
         check({tag, "_stall_done"}, 64'(stall), 64'(0));
         @(negedge clk);
         check({tag, "_done_pulse"}, 64'(done), 64'(0));
         check({tag, "_idle_busy"}, 64'(busy), 64'(0));
      end
   endtask

   initial begin
      logic [31:0] eh, el, a, b;
      logic        ed;
      logic [1:0]  o;
      int          done_seen;

      rst_b = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
      repeat (3) @(negedge clk);
      check("rst_hi",    64'(hi), 64'(0));
      check("rst_lo",    64'(lo), 64'(0));
      check("rst_done",  64'(done), 64'(0));
      check("rst_busy",  64'(busy), 64'(0));
      check("rst_stall", 64'(stall), 64'(0));
      check("rst_dbz",   64'(div_by_zero), 64'(0));
      rst_b = 1'b1;
      @(negedge clk);

      run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
      run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op("div_b2b",   2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
      run_op("divu_zero", 2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b1);
      run_op("div_zero",  2'b11, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1'b1);
      run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
      run_op("setup",     2'b10, 32'h0000_2211, 32'h0000_0100, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b1);

      // flush mid-RUN, with a stray start that must be ignored
      issue("flush", 2'b01, 32'd5, 32'd6);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 2'b00; rs_data = 32'd9; rt_data = 32'd9;
      #1 check("ign_start_stall", 64'(stall), 64'(1));
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      #1 check("flush_stall_same", 64'(stall), 64'(1));
      @(negedge clk);
      flush = 1'b0;
      check("flush_stall_next", 64'(stall), 64'(0));
      check("flush_busy_next",  64'(busy), 64'(0));
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      check("flush_no_done", 64'(done_seen), 64'(0));
      check("flush_hi", 64'(hi), 64'(32'h11));
      check("flush_lo", 64'(lo), 64'(32'h22));

      // flush wins over a same-cycle start in IDLE
      start = 1'b1; flush = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_idle_busy", 64'(busy), 64'(0));

      // synchronous reset in the middle of a divide
      issue("rst_mid", 2'b10, 32'd50, 32'd7);
      repeat (20) @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      check("rstmid_busy",  64'(busy), 64'(0));
      check("rstmid_stall", 64'(stall), 64'(0));
      check("rstmid_hi",    64'(hi), 64'(0));
      check("rstmid_lo",    64'(lo), 64'(0));
      check("rstmid_done",  64'(done), 64'(0));
      rst_b = 1'b1;
      @(negedge clk);
      run_op("divu_after_rst", 2'b10, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         model(o, a, b, eh, el, ed);
         run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, eh, el, ed, (i == 39) || ($urandom_range(0, 1) == 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
